// File: rtl/k_frame_reader.sv
// ---------------------------------------------------------------------------
// k_frame_reader
//
// Reads one frame from a line-banked pixel memory in raster order. The
// memory answers one cycle after each read. Pixels go out on a
// valid/ready stream. Start/end of line and frame markers travel with
// each pixel. A 3-entry output buffer absorbs stalls on the stream side.
// Reads are only issued while the buffered and in-flight words together
// total fewer than 3, so no returning word can ever be dropped.
//
// Optional feature (macro K_FRAME_READER_CONT_EN):
//   Adds input 'cont'. If cont is high when the last read of a frame
//   issues, the scan wraps to (0,0) with no gap. done then pulses once per
//   frame, one cycle after that frame's final pixel is transferred.
//   Without the macro the 'cont' port does not exist and each start runs
//   exactly one frame.
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   start               frame request, sampled only while idle
//   rd_en/rd_addr/rd_bank  memory read request (column, line)
//   rd_data             read data, valid the cycle after rd_en
//   pix_data/pix_valid/pix_ready  output pixel stream
//   pix_sol/eol/sof/eof markers, qualified by pix_valid
//   busy                high while a frame is in progress
//   done                single-cycle end-of-frame pulse
//   cont                (K_FRAME_READER_CONT_EN only) continuous mode
// ---------------------------------------------------------------------------
module k_frame_reader #(
   parameter int LINE_W    = 320,
   parameter int NUM_LINES = 240,
   parameter int DATA_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
`ifdef K_FRAME_READER_CONT_EN
   input  logic              cont,
`endif
   output logic              rd_en,
   output logic [8:0]        rd_addr,
   output logic [7:0]        rd_bank,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_sol,
   output logic              pix_eol,
   output logic              pix_sof,
   output logic              pix_eof,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   localparam logic [8:0] LAST_COL = 9'(LINE_W - 1);
   localparam logic [7:0] LAST_ROW = 8'(NUM_LINES - 1);
   localparam int         ENT_W    = DATA_W + 4;

   state_t            r_state;
   state_t            w_nextState;

   logic [8:0]        r_addr;
   logic [7:0]        r_bank;
   logic              r_inFlight;
   logic [3:0]        r_pendMark;
   logic [ENT_W-1:0]  r_buf [3];
   logic [1:0]        r_wrPtr;
   logic [1:0]        r_rdPtr;
   logic [1:0]        r_count;

   logic              w_cont;
   logic              w_lastRead;
   logic              w_pop;
   logic              w_drainDone;
   logic [ENT_W-1:0]  w_head;
   logic [3:0]        w_issueMark;

`ifdef K_FRAME_READER_CONT_EN
   logic              r_eofDone;
   assign w_cont = cont;
`else
   assign w_cont = 1'b0;
`endif

   assign w_head      = r_buf[r_rdPtr];
   assign w_pop       = pix_valid && pix_ready;
   assign w_lastRead  = rd_en && (r_addr == LAST_COL) && (r_bank == LAST_ROW);
   assign w_drainDone = (r_count == 2'd0) && !r_inFlight;

   // Markers are decided from the address at issue time, packed as
   // {sof, eof, sol, eol}, and stored alongside the returning word.
   assign w_issueMark = {(r_addr == 9'd0) && (r_bank == 8'd0),
                         (r_addr == LAST_COL) && (r_bank == LAST_ROW),
                         (r_addr == 9'd0),
                         (r_addr == LAST_COL)};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic; continuous mode simply stays in READ across frames
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (start) w_nextState = S_READ;
         S_READ:  if (w_lastRead && !w_cont) w_nextState = S_DRAIN;
         S_DRAIN: if (w_drainDone) w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // Output logic. Stream outputs are gated by pix_valid so that an empty
   // buffer always presents zeros, whatever stale words it still holds.
   always_comb begin
      rd_en     = (r_state == S_READ) &&
                  (({1'b0, r_count} + {2'b00, r_inFlight}) < 3'd3);
      busy      = (r_state != S_IDLE);
      pix_valid = (r_count != 2'd0);
      pix_data  = pix_valid ? w_head[DATA_W-1:0] : '0;
      pix_sof   = pix_valid && w_head[DATA_W+3];
      pix_eof   = pix_valid && w_head[DATA_W+2];
      pix_sol   = pix_valid && w_head[DATA_W+1];
      pix_eol   = pix_valid && w_head[DATA_W];
`ifdef K_FRAME_READER_CONT_EN
      done      = r_eofDone;
`else
      done      = (r_state == S_DRAIN) && w_drainDone;
`endif
   end

   assign rd_addr = r_addr;
   assign rd_bank = r_bank;

   // Raster address counter: restarts at (0,0) when a frame is accepted and
   // wraps back to (0,0) after the last read so continuous mode has no gap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= 9'd0;
         r_bank <= 8'd0;
      end else if ((r_state == S_IDLE) && start) begin
         r_addr <= 9'd0;
         r_bank <= 8'd0;
      end else if (rd_en) begin
         if (r_addr == LAST_COL) begin
            r_addr <= 9'd0;
            r_bank <= (r_bank == LAST_ROW) ? 8'd0 : r_bank + 8'd1;
         end else begin
            r_addr <= r_addr + 9'd1;
         end
      end
   end

   // One-deep read pipeline matching the memory latency. Clearing it on
   // reset is what discards a word that returns after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inFlight <= 1'b0;
         r_pendMark <= 4'd0;
      end else begin
         r_inFlight <= rd_en;
         if (rd_en) begin
            r_pendMark <= w_issueMark;
         end
      end
   end

   // Buffer storage; contents need no reset because they are only visible
   // through the occupancy-gated outputs.
   always_ff @(posedge clk) begin
      if (r_inFlight) begin
         r_buf[r_wrPtr] <= {r_pendMark, rd_data};
      end
   end

   // Buffer pointers and occupancy (modulo-3 ring)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= 2'd0;
         r_rdPtr <= 2'd0;
         r_count <= 2'd0;
      end else begin
         if (r_inFlight) begin
            r_wrPtr <= (r_wrPtr == 2'd2) ? 2'd0 : r_wrPtr + 2'd1;
         end
         if (w_pop) begin
            r_rdPtr <= (r_rdPtr == 2'd2) ? 2'd0 : r_rdPtr + 2'd1;
         end
         case ({r_inFlight, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef K_FRAME_READER_CONT_EN
   // Per-frame completion: flag the cycle after an end-of-frame pixel leaves
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_eofDone <= 1'b0;
      end else begin
         r_eofDone <= w_pop && w_head[DATA_W+2];
      end
   end
`endif

endmodule

// File: tb/tb_k_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_k_frame_reader
//
// Drives k_frame_reader with LINE_W=4, NUM_LINES=2 against a memory whose
// word at (bank,addr) is {bank,addr}. Outside the valid slot, the memory
// returns random junk. The reference is a plain raster list of expected
// pixels and markers, built from the frame geometry.
// ---------------------------------------------------------------------------
module tb_k_frame_reader;

   localparam int LW    = 4;
   localparam int NL    = 2;
   localparam int TOTAL = LW * NL;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        cont;
   logic        rd_en;
   logic [8:0]  rd_addr;
   logic [7:0]  rd_bank;
   logic [31:0] rd_data;
   logic [31:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_sol, pix_eol, pix_sof, pix_eof;
   logic        busy;
   logic        done;

   int total;
   int bad;

   logic [31:0] expData[$];
   logic [3:0]  expMark[$];
   logic [31:0] obsData[$];
   logic [3:0]  obsMark[$];
   int          obsK[$];
   int          doneK[$];
   int          readK[$];
   int          stallChange;
   int          overOut;
   bit          timedOut;
   logic        busyFirst;

   k_frame_reader #(.LINE_W(LW), .NUM_LINES(NL), .DATA_W(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
`ifdef K_FRAME_READER_CONT_EN
      .cont(cont),
`endif
      .rd_en(rd_en),
      .rd_addr(rd_addr),
      .rd_bank(rd_bank),
      .rd_data(rd_data),
      .pix_data(pix_data),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .pix_sol(pix_sol),
      .pix_eol(pix_eol),
      .pix_sof(pix_sof),
      .pix_eof(pix_eof),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   // Memory: answers one cycle after rd_en, junk otherwise
   always @(posedge clk) begin
      rd_data <= rd_en ? {15'd0, rd_bank, rd_addr} : $urandom();
   end

   // Expected raster sequence for a number of back-to-back frames
   task automatic buildExpected(input int frames);
      expData.delete();
      expMark.delete();
      for (int f = 0; f < frames; f++)
         for (int b = 0; b < NL; b++)
            for (int a = 0; a < LW; a++) begin
               expData.push_back({15'd0, 8'(b), 9'(a)});
               expMark.push_back({(a == 0 && b == 0), (a == LW-1 && b == NL-1),
                                  (a == 0), (a == LW-1)});
            end
   endtask

   // Drives pix_ready per mode after start has been raised, and records
   // transfers, reads, done pulses and handshake violations. k counts
   // cycles after the edge that accepted start.
   task automatic runStream(input int mode, input int expDone, input int restartAt,
                            input int contFrames, input int budget);
      int          k;
      int          outstanding;
      int          issued;
      bit          finished;
      bit          prevStall;
      logic [31:0] prevData;
      logic [3:0]  prevMark;
      obsData.delete(); obsMark.delete(); obsK.delete();
      doneK.delete(); readK.delete();
      stallChange = 0; overOut = 0; timedOut = 0;
      k = 0; outstanding = 0; issued = 0; finished = 0; prevStall = 0;
      prevData = '0; prevMark = '0; busyFirst = 1'b0;
      while (!finished) begin
         @(negedge clk);
         k++;
         if (k == 1) start = 1'b0;
         if (restartAt != 0) start = (k == restartAt);
         case (mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ((k-1) % 4 == 0) || ((k-1) % 4 == 3);
            2:       pix_ready = (k > 20);
            default: pix_ready = 1'($urandom_range(0, 1));
         endcase
         cont = (issued < (contFrames - 1) * TOTAL);
         if (k == 1) busyFirst = busy;
         if (prevStall && (!pix_valid || pix_data !== prevData ||
             {pix_sof, pix_eof, pix_sol, pix_eol} !== prevMark))
            stallChange++;
         if (rd_en) begin
            if (outstanding >= 3) overOut++;
            readK.push_back(k);
            issued++;
            outstanding++;
         end
         if (pix_valid && pix_ready) begin
            obsData.push_back(pix_data);
            obsMark.push_back({pix_sof, pix_eof, pix_sol, pix_eol});
            obsK.push_back(k);
            outstanding--;
         end
         if (done) doneK.push_back(k);
         prevStall = pix_valid && !pix_ready;
         prevData  = pix_data;
         prevMark  = {pix_sof, pix_eof, pix_sol, pix_eol};
         if (doneK.size() >= expDone && doneK.size() > 0 && k >= doneK[$] + 6)
            finished = 1;
         else if (k >= budget) begin
            timedOut = 1;
            finished = 1;
         end
      end
      cont = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      total++;
      if ({rd_en, rd_addr, rd_bank, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof,
           busy, done, pix_data} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_outputs got=%h want=0", {rd_en, rd_addr, rd_bank,
                  pix_valid, pix_sol, pix_eol, pix_sof, pix_eof, busy, done, pix_data});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, rd_en, pix_valid} !== 3'b000) begin
         bad++;
         $display("[TB] FAIL idle_after_reset got=%b want=000", {busy, rd_en, pix_valid});
      end
   endtask

   task automatic test_basic;
      buildExpected(1);
      @(negedge clk) start = 1'b1;
      runStream(0, 1, 0, 1, 200);
      total++;
      if (timedOut) begin bad++; $display("[TB] FAIL basic_timeout got=1 want=0"); end
      total++;
      if (obsData.size() != TOTAL) begin
         bad++; $display("[TB] FAIL basic_count got=%0d want=%0d", obsData.size(), TOTAL);
      end
      for (int i = 0; i < TOTAL; i++) begin
         total++;
         if (i >= obsData.size() || {obsData[i], obsMark[i]} !== {expData[i], expMark[i]}) begin
            bad++;
            $display("[TB] FAIL basic_pixel[%0d] got=%h want=%h", i,
                     (i < obsData.size()) ? {obsData[i], obsMark[i]} : 36'hx,
                     {expData[i], expMark[i]});
         end
         total++;
         if (i >= obsK.size() || obsK[i] != 3 + i) begin
            bad++;
            $display("[TB] FAIL basic_cycle[%0d] got=%0d want=%0d", i,
                     (i < obsK.size()) ? obsK[i] : -1, 3 + i);
         end
      end
      total++;
      if (readK.size() == 0 || readK[0] != 1) begin
         bad++; $display("[TB] FAIL basic_first_read got=%0d want=1",
                         (readK.size() > 0) ? readK[0] : -1);
      end
      total++;
      if (busyFirst !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy got=%b want=1", busyFirst); end
      total++;
      if (doneK.size() != 1 || obsK.size() != TOTAL || doneK[0] != obsK[TOTAL-1] + 1) begin
         bad++; $display("[TB] FAIL basic_done got=%0d pulses want=1 at last+1", doneK.size());
      end
      total++;
      if ({busy, pix_valid} !== 2'b00) begin
         bad++; $display("[TB] FAIL basic_idle_end got=%b want=00", {busy, pix_valid});
      end
   endtask

   task automatic test_stall;
      buildExpected(1);
      @(negedge clk) start = 1'b1;
      runStream(1, 1, 0, 1, 300);
      total++;
      if (timedOut || obsData.size() != TOTAL) begin
         bad++; $display("[TB] FAIL stall_count got=%0d want=%0d", obsData.size(), TOTAL);
      end
      for (int i = 0; i < TOTAL; i++) begin
         total++;
         if (i >= obsData.size() || {obsData[i], obsMark[i]} !== {expData[i], expMark[i]}) begin
            bad++; $display("[TB] FAIL stall_pixel[%0d] want=%h", i, {expData[i], expMark[i]});
         end
      end
      total++;
      if (stallChange != 0) begin bad++; $display("[TB] FAIL stall_hold got=%0d want=0", stallChange); end
      total++;
      if (overOut != 0) begin bad++; $display("[TB] FAIL stall_outstanding got=%0d want=0", overOut); end
      total++;
      if (doneK.size() != 1) begin bad++; $display("[TB] FAIL stall_done got=%0d want=1", doneK.size()); end
   endtask

   task automatic test_hold20;
      int early;
      buildExpected(1);
      @(negedge clk) start = 1'b1;
      runStream(2, 1, 0, 1, 300);
      early = 0;
      foreach (readK[i]) if (readK[i] <= 20) early++;
      total++;
      if (early != 3) begin bad++; $display("[TB] FAIL hold_reads got=%0d want=3", early); end
      total++;
      if (obsK.size() > 0 && obsK[0] <= 20) begin
         bad++; $display("[TB] FAIL hold_early_xfer got=%0d want>20", obsK[0]);
      end
      total++;
      if (timedOut || obsData.size() != TOTAL) begin
         bad++; $display("[TB] FAIL hold_count got=%0d want=%0d", obsData.size(), TOTAL);
      end
      for (int i = 0; i < TOTAL; i++) begin
         total++;
         if (i >= obsData.size() || {obsData[i], obsMark[i]} !== {expData[i], expMark[i]}) begin
            bad++; $display("[TB] FAIL hold_pixel[%0d] want=%h", i, {expData[i], expMark[i]});
         end
      end
   endtask

   task automatic test_busy_start;
      int restarts[2] = '{5, 9};
      buildExpected(1);
      for (int r = 0; r < 2; r++) begin
         @(negedge clk) start = 1'b1;
         runStream(0, 1, restarts[r], 1, 200);
         total++;
         if (obsData.size() != TOTAL || readK.size() != TOTAL) begin
            bad++; $display("[TB] FAIL busy_start_%0d got=%0d pixels %0d reads want=%0d", restarts[r],
                            obsData.size(), readK.size(), TOTAL);
         end
         total++;
         if (doneK.size() != 1) begin
            bad++; $display("[TB] FAIL busy_start_done_%0d got=%0d want=1", restarts[r], doneK.size());
         end
      end
   endtask

   task automatic test_random;
      buildExpected(1);
      for (int r = 0; r < 3; r++) begin
         @(negedge clk) start = 1'b1;
         runStream(3, 1, 0, 1, 400);
         total++;
         if (timedOut || obsData.size() != TOTAL) begin
            bad++; $display("[TB] FAIL rand_count got=%0d want=%0d", obsData.size(), TOTAL);
         end
         for (int i = 0; i < TOTAL; i++) begin
            total++;
            if (i >= obsData.size() || {obsData[i], obsMark[i]} !== {expData[i], expMark[i]}) begin
               bad++; $display("[TB] FAIL rand_pixel[%0d] want=%h", i, {expData[i], expMark[i]});
            end
         end
         total++;
         if (stallChange != 0 || overOut != 0) begin
            bad++; $display("[TB] FAIL rand_protocol got=%0d/%0d want=0/0", stallChange, overOut);
         end
      end
   endtask

   task automatic test_reset_mid;
      int  xfer;
      bit  hit;
      xfer = 0; hit = 0;
      @(negedge clk) start = 1'b1;
      for (int k = 1; k <= 60 && !hit; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         pix_ready = 1'b1;
         if (pix_valid && xfer == 5) begin
            rst_n = 1'b0;
            #1;
            hit = 1;
         end else if (pix_valid) xfer++;
      end
      total++;
      if (!hit) begin
         bad++; $display("[TB] FAIL midreset_reach got=%0d pixels want=5", xfer);
      end
      total++;
      if ({rd_en, rd_addr, rd_bank, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof,
           busy, done, pix_data} !== '0) begin
         bad++; $display("[TB] FAIL midreset_outputs got=%h want=0", {rd_en, rd_addr, rd_bank,
                         pix_valid, pix_sol, pix_eol, pix_sof, pix_eof, busy, done, pix_data});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      buildExpected(1);
      @(negedge clk) start = 1'b1;
      runStream(0, 1, 0, 1, 200);
      total++;
      if (obsData.size() == 0 || {obsData[0], obsMark[0]} !== {expData[0], expMark[0]}) begin
         bad++; $display("[TB] FAIL midreset_first got=%h want=%h",
                         (obsData.size() > 0) ? obsData[0] : 32'hx, expData[0]);
      end
      total++;
      if (obsData.size() != TOTAL) begin
         bad++; $display("[TB] FAIL midreset_count got=%0d want=%0d", obsData.size(), TOTAL);
      end
      for (int i = 0; i < TOTAL; i++) begin
         total++;
         if (i >= obsData.size() || obsData[i] !== expData[i]) begin
            bad++; $display("[TB] FAIL midreset_pixel[%0d] want=%h", i, expData[i]);
         end
      end
   endtask

`ifdef K_FRAME_READER_CONT_EN
   task automatic test_cont;
      buildExpected(2);
      @(negedge clk) start = 1'b1;
      runStream(0, 2, 0, 2, 300);
      total++;
      if (timedOut || obsData.size() != 2 * TOTAL) begin
         bad++; $display("[TB] FAIL cont_count got=%0d want=%0d", obsData.size(), 2 * TOTAL);
      end
      for (int i = 0; i < 2 * TOTAL; i++) begin
         total++;
         if (i >= obsData.size() || {obsData[i], obsMark[i]} !== {expData[i], expMark[i]} ||
             obsK[i] != 3 + i) begin
            bad++; $display("[TB] FAIL cont_pixel[%0d] want=%h at %0d", i,
                            {expData[i], expMark[i]}, 3 + i);
         end
      end
      total++;
      if (doneK.size() != 2 || doneK[0] != 3 + TOTAL || doneK[1] != 3 + 2 * TOTAL) begin
         bad++; $display("[TB] FAIL cont_done got=%0d pulses want=2 at %0d,%0d",
                         doneK.size(), 3 + TOTAL, 3 + 2 * TOTAL);
      end
   endtask
`endif

   initial begin
      clk = 1'b0; rst_n = 1'b0; start = 1'b0; cont = 1'b0; pix_ready = 1'b0;
      total = 0; bad = 0;
      test_reset;
      test_basic;
      test_stall;
      test_hold20;
      test_busy_start;
      test_random;
      test_reset_mid;
`ifdef K_FRAME_READER_CONT_EN
      test_cont;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
